// File: rtl/imm_encoder.sv
// imm_encoder: packs rd/rs1/rs2/funct3 and a signed immediate into an RV32I
// load, OP-IMM, store, branch or JAL word through a two-entry elastic pipe.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid, in_ready    request handshake
//   fmt, rd, rs1, rs2     format select and register fields
//   funct3, imm           funct3 field and signed immediate (byte offset)
//   out_valid, out_ready  result handshake
//   inst_code, err_code   packed word (NOP on error) and error code
//   enc_count, err_count  saturating counts of delivered ok / error words
module imm_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       fmt,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic [31:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      inst_code,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [2:0] F_LOAD = 3'd0;
   localparam logic [2:0] F_ALU  = 3'd1;
   localparam logic [2:0] F_ST   = 3'd2;
   localparam logic [2:0] F_BR   = 3'd3;
   localparam logic [2:0] F_JAL  = 3'd4;

   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_ALU  = 7'b0010011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [1:0] E_OK    = 2'd0;
   localparam logic [1:0] E_RANGE = 2'd1;
   localparam logic [1:0] E_ALIGN = 2'd2;
   localparam logic [1:0] E_FMT   = 2'd3;

   localparam logic [31:0]      NOP     = 32'h0000_0013;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [31:0] imm;
   } req_t;

   logic        s1_valid;
   req_t        s1;
   logic        s2_free;
   logic        s1_adv;
   logic        in_fire;
   logic        out_fire;

   logic        fit12;
   logic        fit13;
   logic        fit21;
   logic        bad_fmt;
   logic        misalign;
   logic        range_bad;
   logic [31:0] packed_word;
   logic [1:0]  err;
   logic [31:0] word;

   assign s2_free  = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_free;
   assign in_ready = !s1_valid || s2_free;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // ---------------------------------------------------------------
   // Stage 1: request capture
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && in_fire) begin
         s1.fmt    <= fmt;
         s1.rd     <= rd;
         s1.rs1    <= rs1;
         s1.rs2    <= rs2;
         s1.funct3 <= funct3;
         s1.imm    <= imm;
      end
   end

   // ---------------------------------------------------------------
   // Stage 1: checks and packing
   // ---------------------------------------------------------------
   // An immediate fits in N signed bits when every bit from N-1 up to
   // 31 is a copy of the sign.
   assign fit12 = (&s1.imm[31:11]) || !(|s1.imm[31:11]);
   assign fit13 = (&s1.imm[31:12]) || !(|s1.imm[31:12]);
   assign fit21 = (&s1.imm[31:20]) || !(|s1.imm[31:20]);

   always_comb begin
      bad_fmt     = 1'b0;
      misalign    = 1'b0;
      range_bad   = 1'b0;
      packed_word = NOP;
      case (s1.fmt)
         F_LOAD: begin
            range_bad   = !fit12;
            packed_word = {s1.imm[11:0], s1.rs1, s1.funct3,
                           s1.rd, OP_LOAD};
         end
         F_ALU: begin
            range_bad   = !fit12;
            packed_word = {s1.imm[11:0], s1.rs1, s1.funct3,
                           s1.rd, OP_ALU};
         end
         F_ST: begin
            range_bad   = !fit12;
            packed_word = {s1.imm[11:5], s1.rs2, s1.rs1,
                           s1.funct3, s1.imm[4:0], OP_ST};
         end
         F_BR: begin
            misalign    = s1.imm[0];
            range_bad   = !fit13;
            packed_word = {s1.imm[12], s1.imm[10:5], s1.rs2,
                           s1.rs1, s1.funct3, s1.imm[4:1],
                           s1.imm[11], OP_BR};
         end
         F_JAL: begin
            misalign    = s1.imm[0];
            range_bad   = !fit21;
            packed_word = {s1.imm[20], s1.imm[10:1], s1.imm[11],
                           s1.imm[19:12], s1.rd, OP_JAL};
         end
         default: begin
            bad_fmt = 1'b1;
         end
      endcase
   end

   always_comb begin
      if (bad_fmt) begin
         err = E_FMT;
      end else if (misalign) begin
         err = E_ALIGN;
      end else if (range_bad) begin
         err = E_RANGE;
      end else begin
         err = E_OK;
      end
      word = (err == E_OK) ? packed_word : NOP;
   end

   // ---------------------------------------------------------------
   // Stage 2: output holding register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         inst_code <= '0;
         err_code  <= E_OK;
      end else if (s2_free) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            inst_code <= word;
            err_code  <= err;
         end
      end
   end

   // ---------------------------------------------------------------
   // Delivery statistics
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (out_fire) begin
         if (err_code == E_OK) begin
            if (enc_count != CNT_MAX) begin
               enc_count <= enc_count + CNT_W'(1);
            end
         end else if (err_count != CNT_MAX) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized checks of imm_encoder against a
// field-arithmetic reference model and an in-order expected-word queue.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_ready2;
   logic [2:0]  fmt;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_valid2;
   logic        out_ready;
   logic [31:0] inst_code;
   logic [31:0] inst_code2;
   logic [1:0]  err_code;
   logic [1:0]  err_code2;
   logic [15:0] enc_count;
   logic [15:0] err_count;
   logic [1:0]  enc_count2;
   logic [1:0]  err_count2;

   int vectors = 0;
   int miscompares = 0;
   bit rand_ready = 1'b0;

   typedef struct packed {
      logic [31:0] word;
      logic [1:0]  err;
   } exp_t;

   exp_t        exp_q[$];
   int          m_enc = 0;
   int          m_err = 0;
   int          m_enc2 = 0;
   int          m_err2 = 0;
   logic [31:0] last_inst;
   logic [1:0]  last_err;

   always #5 clk = ~clk;

   imm_encoder #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .inst_code(inst_code), .err_code(err_code),
      .enc_count(enc_count), .err_count(err_count)
   );

   imm_encoder #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready2),
      .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .imm(imm),
      .out_valid(out_valid2), .out_ready(out_ready),
      .inst_code(inst_code2), .err_code(err_code2),
      .enc_count(enc_count2), .err_count(err_count2)
   );

   // Reference: legality from signed value ranges, packing by shifting
   // each immediate slice into its instruction bit position.
   function automatic exp_t model(input logic [2:0] f, input logic [4:0] d,
                                  input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [2:0] f3, input logic [31:0] im);
      exp_t        x;
      longint      v;
      longint      lim;
      logic [31:0] u, dd, a, b, ff;
      v  = longint'($signed(im));
      u  = im;
      dd = 32'(d);
      a  = 32'(s1);
      b  = 32'(s2);
      ff = 32'(f3);
      lim = (f == 3) ? 4096 : (f == 4) ? (64'd1 << 20) : 2048;
      x.err = 2'd0;
      if (f > 3'd4) x.err = 2'd3;
      else if ((f == 3 || f == 4) && (v % 2 != 0)) x.err = 2'd2;
      else if (v < -lim || v >= lim) x.err = 2'd1;
      x.word = 32'h13;
      if (x.err == 2'd0) begin
         case (f)
            3'd0: x.word = ((u & 32'hFFF) << 20) | (a << 15) | (ff << 12)
                           | (dd << 7) | 32'h03;
            3'd1: x.word = ((u & 32'hFFF) << 20) | (a << 15) | (ff << 12)
                           | (dd << 7) | 32'h13;
            3'd2: x.word = (((u >> 5) & 32'h7F) << 25) | (b << 20)
                           | (a << 15) | (ff << 12)
                           | ((u & 32'h1F) << 7) | 32'h23;
            3'd3: x.word = (((u >> 12) & 1) << 31)
                           | (((u >> 5) & 32'h3F) << 25) | (b << 20)
                           | (a << 15) | (ff << 12)
                           | (((u >> 1) & 32'hF) << 8)
                           | (((u >> 11) & 1) << 7) | 32'h63;
            default: x.word = (((u >> 20) & 1) << 31)
                           | (((u >> 1) & 32'h3FF) << 21)
                           | (((u >> 11) & 1) << 20)
                           | (((u >> 12) & 32'hFF) << 12)
                           | (dd << 7) | 32'h6F;
         endcase
      end
      return x;
   endfunction

   function automatic logic [31:0] rand_imm(input logic [2:0] f);
      int lim;
      int off;
      lim = (f == 3) ? 4096 : (f == 4) ? (1 << 20) : 2048;
      off = int'($urandom_range(0, 3)) - 2;
      case ($urandom_range(0, 4))
         0: return $urandom;
         1: return 32'(lim + off);
         2: return 32'(-lim + off);
         default: return 32'(int'($urandom_range(0, 2 * lim - 1)) - lim);
      endcase
   endfunction

   always @(negedge clk) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // Output monitor: sampled just before the rising edge it describes.
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (reset) begin
         exp_q.delete();
         m_enc = 0; m_err = 0; m_enc2 = 0; m_err2 = 0;
      end else if (out_valid && out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL stale_word got %h want no word", inst_code);
         end else begin
            e = exp_q.pop_front();
            if (inst_code !== e.word || err_code !== e.err) begin
               miscompares++;
               $display("FAIL word got %h/%0d want %h/%0d",
                        inst_code, err_code, e.word, e.err);
            end
         end
         vectors++;
         if (enc_count !== 16'(m_enc) || err_count !== 16'(m_err)) begin
            miscompares++;
            $display("FAIL counts got %0d/%0d want %0d/%0d",
                     enc_count, err_count, m_enc, m_err);
         end
         vectors++;
         if (enc_count2 !== 2'(m_enc2) || err_count2 !== 2'(m_err2)) begin
            miscompares++;
            $display("FAIL sat_counts got %0d/%0d want %0d/%0d",
                     enc_count2, err_count2, m_enc2, m_err2);
         end
         last_inst = inst_code;
         last_err  = err_code;
         if (err_code == 2'd0) begin
            m_enc++;
            if (m_enc2 < 3) m_enc2++;
         end else begin
            m_err++;
            if (m_err2 < 3) m_err2++;
         end
      end
   end

   task automatic send(input logic [2:0] f, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] f3, input logic [31:0] im);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
      #1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout got in_ready=0 want 1");
         in_valid = 1'b0;
      end else begin
         exp_q.push_back(model(f, d, s1, s2, f3, im));
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout got %0d left want 0", exp_q.size());
      end
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      fmt = 3'd1; rd = 5'd3; rs1 = 5'd4; rs2 = 5'd5;
      funct3 = 3'd0; imm = 32'd7;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      vectors++;
      if (out_valid !== 1'b0 || inst_code !== 32'h0 || err_code !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_out got %b/%h/%0d want 0/0/0",
                  out_valid, inst_code, err_code);
      end
      vectors++;
      if (enc_count !== 16'd0 || err_count !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_counts got %0d/%0d want 0/0",
                  enc_count, err_count);
      end
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ignored got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_directed();
      logic [31:0] want[4];
      want[0] = 32'hFFF1_0093;
      want[1] = 32'h0051_2423;
      want[2] = 32'hFE20_8EE3;
      want[3] = 32'h0010_00EF;
      pulse_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: send(3'd1, 5'd1, 5'd2, 5'd9, 3'd0, 32'hFFFF_FFFF);
            1: send(3'd2, 5'd7, 5'd2, 5'd5, 3'd2, 32'd8);
            2: send(3'd3, 5'd9, 5'd1, 5'd2, 3'd0, -32'sd4);
            default: send(3'd4, 5'd1, 5'd6, 5'd7, 3'd5, 32'd2048);
         endcase
         idle();
         drain();
         vectors++;
         if (last_inst !== want[i] || last_err !== 2'd0) begin
            miscompares++;
            $display("FAIL directed_%0d got %h/%0d want %h/0",
                     i, last_inst, last_err, want[i]);
         end
         vectors++;
         if (enc_count !== 16'(i + 1)) begin
            miscompares++;
            $display("FAIL directed_cnt_%0d got %0d want %0d",
                     i, enc_count, i + 1);
         end
      end
   endtask

   task automatic test_errors();
      logic [1:0] want[3];
      want[0] = 2'd2;
      want[1] = 2'd1;
      want[2] = 2'd3;
      pulse_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: send(3'd3, 5'd1, 5'd1, 5'd2, 3'd0, 32'd3);
            1: send(3'd1, 5'd1, 5'd2, 5'd3, 3'd0, 32'd2048);
            default: send(3'd6, 5'd1, 5'd2, 5'd3, 3'd0, 32'd3);
         endcase
         idle();
         drain();
         vectors++;
         if (last_err !== want[i] || last_inst !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL error_%0d got %h/%0d want 00000013/%0d",
                     i, last_inst, last_err, want[i]);
         end
      end
      vectors++;
      if (err_count !== 16'd3 || enc_count !== 16'd0) begin
         miscompares++;
         $display("FAIL err_count got %0d/%0d want 3/0",
                  err_count, enc_count);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      logic [1:0]  held_err;
      pulse_reset();
      @(negedge clk);
      out_ready = 1'b0;
      send(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 32'd1);
      send(3'd0, 5'd2, 5'd2, 5'd0, 3'd2, 32'd2);
      @(negedge clk);
      fmt = 3'd2; rd = 5'd0; rs1 = 5'd3; rs2 = 5'd4;
      funct3 = 3'd1; imm = 32'hFFFF_F800;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_in_ready got %b want 0", in_ready);
      end
      held = inst_code;
      held_err = err_code;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         vectors++;
         if (out_valid !== 1'b1 || inst_code !== held
             || err_code !== held_err || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_%0d got %b/%h/%b want 1/%h/0",
                     k, out_valid, inst_code, in_ready, held);
         end
      end
      out_ready = 1'b1;
      exp_q.push_back(model(3'd2, 5'd0, 5'd3, 5'd4, 3'd1, 32'hFFFF_F800));
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
         end
         vectors++;
         if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL release_%0d got out_valid=%b want 1", k, out_valid);
         end
      end
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL release_end got %b/%b/%0d want 0/1/0",
                  out_valid, in_ready, exp_q.size());
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      out_ready = 1'b0;
      send(3'd1, 5'd5, 5'd6, 5'd0, 3'd0, 32'd5);
      send(3'd4, 5'd7, 5'd0, 5'd0, 3'd0, 32'd16);
      pulse_reset();
      #1;
      vectors++;
      if (out_valid !== 1'b0 || enc_count !== 16'd0
          || err_count !== 16'd0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset got %b/%0d/%0d/%b want 0/0/0/1",
                  out_valid, enc_count, err_count, in_ready);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_after_reset got %h want none", inst_code);
         end
      end
   endtask

   task automatic test_saturation();
      pulse_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(3'd1, 5'(i), 5'(i + 1), 5'd0, 3'd0, 32'(i * 3));
      end
      idle();
      drain();
      vectors++;
      if (enc_count2 !== 2'd3 || enc_count !== 16'd5) begin
         miscompares++;
         $display("FAIL saturation got %0d/%0d want 3/5",
                  enc_count2, enc_count);
      end
   endtask

   task automatic test_back_to_back_random();
      logic [2:0] f;
      pulse_reset();
      rand_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         f = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4))
                                         : 3'($urandom_range(5, 7));
         send(f, 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), rand_imm(f));
         if ($urandom_range(0, 7) == 0) idle();
      end
      idle();
      @(negedge clk);
      rand_ready = 1'b0;
      #1;
      out_ready = 1'b1;
      drain();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_errors();
      test_backpressure();
      test_mid_reset();
      test_saturation();
      test_back_to_back_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
